// File: rtl/multdiv_writeback_arbiter_pkg.sv
// Shared constants, entry layout and starvation states
// for the multdiv writeback arbiter.
package multdiv_writeback_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int OP_HI  = 6;
    localparam int OP_LO  = 2;

    localparam logic [REG_W-1:0] RSTATUS  = 5'd30;
    localparam logic [XLEN-1:0]  MULT_EXC = 32'd4;
    localparam logic [XLEN-1:0]  DIV_EXC  = 32'd5;
    localparam logic [4:0]       ALU_MULT = 5'b00110;
    localparam logic [4:0]       ALU_DIV  = 5'b00111;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } md_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } starve_state_e;

    function automatic md_entry_t form_entry(
        input logic [REG_W-1:0] rd,
        input logic [4:0]       op,
        input logic [XLEN-1:0]  result,
        input logic             exc
    );
        md_entry_t e;
        e.rd   = rd;
        e.data = result;
        if (exc) begin
            e.rd = RSTATUS;
            unique case (1'b1)
                (op == ALU_MULT): e.data = MULT_EXC;
                (op == ALU_DIV):  e.data = DIV_EXC;
                default:          e.data = '0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/multdiv_writeback_arbiter_fifo.sv
// Circular {rd,data} result buffer with separate occupancy count.
// Exposes every slot and its valid bit for hazard comparison.
module md_result_fifo
    import multdiv_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  md_entry_t                  wdata,
    output md_entry_t                  head,
    output md_entry_t [DEPTH-1:0]      slots,
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;
    md_entry_t [DEPTH-1:0] mem;
    logic                  push_ok;
    logic                  pop_ok;
    logic [PTR_W-1:0]      off;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop && !empty;
    // A full buffer still accepts a push when the head leaves this cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];
    assign slots   = mem;
    assign count   = cnt;

    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - rd_ptr;
            valid[i] = ({1'b0, off} < cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            mem    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/multdiv_writeback_arbiter.sv
// Buffers multdiv results and merges them into idle regfile
// write slots; flags RAW hazards and forces stalls on starvation.
module multdiv_writeback_arbiter
    import multdiv_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             md_rdy,
    input  logic [XLEN-1:0]  md_result,
    input  logic [XLEN-1:0]  md_insn,
    input  logic             md_exception,
    input  logic             wb_main_we,
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_rd,
    output logic [XLEN-1:0]  rf_data,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic             stall_main,
    output logic             buf_full,
    output logic             overrun_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    md_entry_t             in_entry;
    md_entry_t             head;
    md_entry_t [DEPTH-1:0] slots;
    logic [DEPTH-1:0]      valid;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  pop;
    logic                  blocked;
    logic                  remaining;
    logic                  hit_a;
    logic                  hit_b;
    logic                  unused_insn_bits;

    starve_state_e         state;
    starve_state_e         state_n;
    logic [SC_W-1:0]       scnt;
    logic [SC_W-1:0]       scnt_n;
    logic [SC_W-1:0]       scnt_inc;

    assign in_entry = form_entry(md_insn[RD_HI:RD_LO],
                                 md_insn[OP_HI:OP_LO],
                                 md_result, md_exception);

    assign unused_insn_bits = ^{md_insn[31:27], md_insn[21:7], md_insn[1:0]};

    assign pop       = !empty && !wb_main_we;
    assign blocked   = !empty && wb_main_we;
    // After a pop, something is left if another entry waits or one arrives.
    assign remaining = (count > CNT_W'(1)) || md_rdy;

    md_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (md_rdy),
        .pop   (pop),
        .wdata (in_entry),
        .head  (head),
        .slots (slots),
        .valid (valid),
        .count (count),
        .full  (buf_full),
        .empty (empty)
    );

    assign rf_we   = pop && (head.rd != '0);
    assign rf_rd   = rf_we ? head.rd : '0;
    assign rf_data = rf_we ? head.data : '0;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && slots[i].rd == src_a) hit_a = 1'b1;
            if (valid[i] && slots[i].rd == src_b) hit_b = 1'b1;
        end
        if (md_rdy && in_entry.rd == src_a) hit_a = 1'b1;
        if (md_rdy && in_entry.rd == src_b) hit_b = 1'b1;
    end

    assign hazard_a = reset && (src_a != '0) && hit_a;
    assign hazard_b = reset && (src_b != '0) && hit_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_err <= 1'b0;
        end else if (md_rdy && buf_full && !pop) begin
            overrun_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            scnt  <= '0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
        end
    end

    assign scnt_inc = scnt + SC_W'(1);

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        unique case (state)
            ST_IDLE: begin
                scnt_n = '0;
                if (blocked) begin
                    state_n = ST_WAIT;
                    scnt_n  = SC_W'(1);
                end
            end
            ST_WAIT: begin
                if (pop) begin
                    state_n = remaining ? ST_WAIT : ST_IDLE;
                    scnt_n  = '0;
                end else if (blocked) begin
                    scnt_n = scnt_inc;
                    if (scnt_inc >= SC_W'(STARVE_LIMIT - 1)) begin
                        state_n = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (pop) begin
                    state_n = remaining ? ST_WAIT : ST_IDLE;
                    scnt_n  = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                scnt_n  = '0;
            end
        endcase
    end

    assign stall_main = (state == ST_FORCE);

endmodule

// File: tb/tb_multdiv_writeback_arbiter.sv
// Randomized bench for multdiv_writeback_arbiter against a
// queue-based model, plus directed literal checks.
module tb_multdiv_writeback_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clock;
    logic        reset;
    logic        md_rdy;
    logic [31:0] md_result;
    logic [31:0] md_insn;
    logic        md_exception;
    logic        wb_main_we;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        hazard_a;
    logic        hazard_b;
    logic        stall_main;
    logic        buf_full;
    logic        overrun_err;

    multdiv_writeback_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .md_rdy(md_rdy),
        .md_result(md_result),
        .md_insn(md_insn),
        .md_exception(md_exception),
        .wb_main_we(wb_main_we),
        .src_a(src_a),
        .src_b(src_b),
        .rf_we(rf_we),
        .rf_rd(rf_rd),
        .rf_data(rf_data),
        .hazard_a(hazard_a),
        .hazard_b(hazard_b),
        .stall_main(stall_main),
        .buf_full(buf_full),
        .overrun_err(overrun_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [36:0] q[$];
    int          streak;
    bit          ov;
    int          n_checks;
    int          n_fail;

    function automatic logic [36:0] form(input logic [31:0] insn,
                                         input logic [31:0] res,
                                         input logic exc);
        logic [4:0] op;
        op = insn[6:2];
        if (!exc) return {insn[26:22], res};
        if (op == 5'd6) return {5'd30, 32'd4};
        if (op == 5'd7) return {5'd30, 32'd5};
        return {5'd30, 32'd0};
    endfunction

    function automatic logic haz(input logic [4:0] s);
        logic [36:0] inc;
        if (s == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i][36:32] == s) return 1'b1;
        inc = form(md_insn, md_result, md_exception);
        if (md_rdy && inc[36:32] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk(input int rd, input int op);
        logic [31:0] w;
        w = $urandom;
        w[26:22] = rd[4:0];
        w[6:2] = op[4:0];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model step: inputs are stable here, they change only at +1.
    task automatic tick();
        logic pop;
        logic blocked;
        @(posedge clock);
        if (!reset) begin
            q.delete();
            streak = 0;
            ov = 1'b0;
        end else begin
            pop = (q.size() != 0) && !wb_main_we;
            blocked = (q.size() != 0) && wb_main_we;
            if (md_rdy && q.size() == DEPTH && !pop) ov = 1'b1;
            streak = blocked ? streak + 1 : 0;
            if (pop) void'(q.pop_front());
            if (md_rdy && q.size() < DEPTH)
                q.push_back(form(md_insn, md_result, md_exception));
        end
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] insn,
                         input logic [31:0] res, input logic exc,
                         input logic wb);
        md_rdy = rdy;
        md_insn = insn;
        md_result = res;
        md_exception = exc;
        wb_main_we = wb;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin : compare
        logic        e_pop;
        logic        e_we;
        logic [36:0] h;
        if (!reset) begin
            chk("rst_rf_we", rf_we, 0);
            chk("rst_rf_rd", rf_rd, 0);
            chk("rst_rf_data", rf_data, 0);
            chk("rst_hazard_a", hazard_a, 0);
            chk("rst_hazard_b", hazard_b, 0);
            chk("rst_stall", stall_main, 0);
            chk("rst_full", buf_full, 0);
            chk("rst_overrun", overrun_err, 0);
        end else begin
            h = (q.size() != 0) ? q[0] : 37'd0;
            e_pop = (q.size() != 0) && !wb_main_we;
            e_we = e_pop && (h[36:32] != 5'd0);
            chk("rf_we", rf_we, e_we);
            chk("rf_rd", rf_rd, e_we ? h[36:32] : 5'd0);
            chk("rf_data", rf_data, e_we ? h[31:0] : 32'd0);
            chk("hazard_a", hazard_a, haz(src_a));
            chk("hazard_b", hazard_b, haz(src_b));
            chk("stall_main", stall_main, streak >= LIMIT - 1);
            chk("buf_full", buf_full, q.size() == DEPTH);
            chk("overrun_err", overrun_err, ov);
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        streak = 0;
        ov = 1'b0;
        src_a = 0;
        src_b = 0;
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        drive(1, mk(5, 0), 32'h2A, 0, 0);
        mid();
        chk("t1_no_bypass", rf_we, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        mid();
        chk("t1_we", rf_we, 1);
        chk("t1_rd", rf_rd, 5);
        chk("t1_data", rf_data, 32'h2A);
        tick();

        drive(1, mk(1, 6), $urandom, 1, 0);
        tick();
        drive(1, mk(2, 7), $urandom, 1, 0);
        mid();
        chk("t2_mult_rd", rf_rd, 30);
        chk("t2_mult_data", rf_data, 4);
        tick();
        drive(0, 0, 0, 0, 0);
        mid();
        chk("t2_div_rd", rf_rd, 30);
        chk("t2_div_data", rf_data, 5);
        tick();

        drive(1, mk(7, 0), 32'h77, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        mid();
        chk("t3_stall_3rd", stall_main, 0);
        tick();
        mid();
        chk("t3_stall_4th", stall_main, 1);
        tick();
        wb_main_we = 0;
        mid();
        chk("t3_drain_we", rf_we, 1);
        chk("t3_drain_rd", rf_rd, 7);
        tick();
        mid();
        chk("t3_stall_off", stall_main, 0);

        drive(1, mk(3, 0), 32'h33, 0, 1);
        tick();
        drive(1, mk(4, 0), 32'h44, 0, 1);
        tick();
        drive(1, mk(11, 0), 32'hBB, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        mid();
        chk("t4_full", buf_full, 1);
        chk("t4_overrun", overrun_err, 1);
        tick();
        wb_main_we = 0;
        mid();
        chk("t4_first_rd", rf_rd, 3);
        tick();
        mid();
        chk("t4_second_rd", rf_rd, 4);
        tick();

        drive(1, mk(9, 0), 32'h99, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        src_a = 9;
        src_b = 0;
        mid();
        chk("t5_hazard_a", hazard_a, 1);
        chk("t5_hazard_b", hazard_b, 0);
        tick();
        drive(1, mk(0, 0), 32'h55, 0, 0);
        src_a = 0;
        tick();
        drive(0, 0, 0, 0, 0);
        mid();
        chk("t5_rd0_silent", rf_we, 0);
        tick();

        drive(1, mk(12, 0), 32'hC, 0, 1);
        tick();
        drive(1, mk(13, 0), 32'hD, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        mid();
        chk("t6_pre_full", buf_full, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_full", buf_full, 0);
        chk("t6_rst_overrun", overrun_err, 0);
        tick();
        reset = 1'b1;
        wb_main_we = 0;
        mid();
        chk("t6_no_write_a", rf_we, 0);
        tick();
        mid();
        chk("t6_no_write_b", rf_we, 0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            int rd;
            int op;
            rd = ($urandom_range(0, 4) == 0) ? 30 : $urandom_range(0, 7);
            op = $urandom_range(0, 3);
            op = (op == 0) ? 6 : (op == 1) ? 7 : $urandom_range(0, 31);
            drive($urandom_range(0, 1), mk(rd, op), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
            src_a = ($urandom_range(0, 4) == 0) ? 30 : $urandom_range(0, 7);
            src_b = ($urandom_range(0, 4) == 0) ? 30 : $urandom_range(0, 7);
            reset = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
